divu8: RTL and testbench



---
 rtl/divu8_pkg.sv | 11 +
 rtl/divu8_step.sv | 34 +++
 rtl/divu8.sv | 119 +++++++++++
 tb/tb_divu8.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/divu8_pkg.sv
// rtl/divu8_pkg.sv - shared constants for the restoring divider
package divu8_pkg;
    localparam int DIVU8_W     = 8;
    localparam int DIVU8_CNT_W = $clog2(DIVU8_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIVU8_W-1:0] DIV0_QUOT = '1;
endpackage

// File: rtl/divu8_step.sv
// rtl/divu8_step.sv - one restoring-division iteration: shift in a dividend bit, trial subtract
module divu8_step
    import divu8_pkg::*;
#(
    parameter int WIDTH = DIVU8_W
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             d_msb_i,
    input  logic [WIDTH-1:0] v_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] vext;
    logic [WIDTH:0] diff;
    logic           carry;

    assign shifted = {r_i, d_msb_i};
    assign vext    = {1'b0, v_i};

    // Ripple subtract as a + ~b + 1, matching the add/sub unit
    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = shifted[i] ^ ~vext[i] ^ carry;
            carry   = (shifted[i] & ~vext[i]) | (carry & (shifted[i] ^ ~vext[i]));
        end
    end

    // R < V keeps the kept remainder within WIDTH bits, so the top bit is dropped
    assign q_bit_o = ~diff[WIDTH];
    assign r_o     = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/divu8.sv
// rtl/divu8.sv - sequential unsigned restoring divider, one quotient bit per cycle
module divu8
    import divu8_pkg::*;
#(
    parameter int WIDTH = DIVU8_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic             step_q;
    logic [WIDTH-1:0] q_next;

    divu8_step #(.WIDTH(WIDTH)) u_step (
        .r_i     (r_q),
        .d_msb_i (d_q[WIDTH-1]),
        .v_i     (v_q),
        .r_o     (step_r),
        .q_bit_o (step_q)
    );

    assign q_next = {q_q[WIDTH-2:0], step_q};

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        v_d     = v_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_CALC: begin
                d_d = d_q << 1;
                r_d = step_r;
                q_d = q_next;
                if (cnt_q == '0) begin
                    // Visible results move only on the done-producing edge
                    quot_d  = q_next;
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = DIV0_QUOT;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        d_d     = dividend;
                        v_d     = divisor;
                        r_d     = '0;
                        q_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = ST_CALC;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            v_q     <= v_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_CALC);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divu8.sv
// tb/tb_divu8.sv - scoreboard bench for divu8
module tb_divu8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    always #5 clk = ~clk;

    divu8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         due;
        int         nbusy;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    logic [7:0] hq = 8'd0;
    logic [7:0] hr = 8'd0;
    logic       hz = 1'b0;
    int         blen = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop on every done pulse, otherwise outputs must hold
    initial forever begin
        @(negedge clk);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", int'(quotient), int'(mon_e.q));
                chk("remainder", int'(remainder), int'(mon_e.r));
                chk("div_by_zero", int'(div_by_zero), int'(mon_e.z));
                chk("done_cycle", cyc, mon_e.due);
                chk("busy_len", blen, mon_e.nbusy);
                chk("busy_in_done", int'(busy), 0);
                hq = mon_e.q;
                hr = mon_e.r;
                hz = mon_e.z;
            end
            blen = 0;
        end else begin
            chk("hold", int'({quotient, remainder, div_by_zero}), int'({hq, hr, hz}));
            if (busy) blen++;
            else blen = 0;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.q     = eq;
        e.r     = er;
        e.z     = ez;
        e.due   = ez ? cyc : cyc + 8;
        e.nbusy = ez ? 0 : 8;
        sb.push_back(e);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int         va[12] = '{0, 1, 2, 7, 37, 100, 127, 128, 199, 200, 254, 255};
    int         vb[12] = '{0, 1, 2, 3, 7, 9, 15, 16, 127, 128, 254, 255};
    logic [7:0] sa, sbv, mq, mr;

    initial begin
        #12;
        chk("reset_outputs", int'({busy, done, quotient, remainder, div_by_zero}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        wait_done();
        @(negedge clk);

        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        wait_done();
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        wait_done();
        @(negedge clk);

        issue(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
        wait_done();
        @(negedge clk);

        issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        issue(8'd50, 8'd7, 8'd7, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        hq   = 8'd0;
        hr   = 8'd0;
        hz   = 1'b0;
        blen = 0;
        #1;
        chk("async_reset", int'({busy, done, quotient, remainder, div_by_zero}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
        wait_done();
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 12; j++) begin
                sa  = 8'(va[i]);
                sbv = 8'(vb[j]);
                mq  = (sbv == 8'd0) ? 8'hFF : sa / sbv;
                mr  = (sbv == 8'd0) ? sa : sa % sbv;
                issue(sa, sbv, mq, mr, sbv == 8'd0);
                wait_done();
                if (((i + j) % 2) == 1) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
